// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmit frame generator.
package uart_tx_pkg;

  localparam int DATA_W_MAX = 9;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  typedef enum logic [1:0] {SEL_START, SEL_DATA, SEL_PAR, SEL_STOP} tx_sel_e;

  // Data is zero-extended to DATA_W_MAX so the padding does not disturb the XOR.
  function automatic logic calc_parity(input logic [DATA_W_MAX-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_out_mux.sv
// Registered 4:1 line selector feeding the UART pin; one clk from select to line.
// Async reset parks the line at the idle level so a reset never glitches the pin.
module uart_tx_out_mux
  import uart_tx_pkg::*;
#(
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  tx_sel_e i_sel,
  input  logic    i_data_bit,
  input  logic    i_par_bit,
  output logic    o_tx_out
);

  logic r_tx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx <= IDLE_LVL;
    end else begin
      case (i_sel)
        SEL_START: r_tx <= ~IDLE_LVL;
        SEL_DATA:  r_tx <= i_data_bit;
        SEL_PAR:   r_tx <= i_par_bit;
        default:   r_tx <= IDLE_LVL;
      endcase
    end
  end

  assign o_tx_out = r_tx;

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART TX frame generator: start, DATA_W bits LSB first, optional parity, STOP_BITS stops.
// Accept-to-start latency 1 clk; o_ready only in IDLE. Define UART_TX_BREAK_EN for i_break.
module uart_tx_frame_gen
  import uart_tx_pkg::*;
#(
  parameter int   DATA_W    = 8,
  parameter int   STOP_BITS = 1,
  parameter logic IDLE_LVL  = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_baud_tick,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_par_en,
  input  logic              i_par_odd,
`ifdef UART_TX_BREAK_EN
  input  logic              i_break,
`endif
  output logic              o_tx_out,
  output logic              o_busy
);

  localparam int              CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

  generate
    if (DATA_W < 5 || DATA_W > DATA_W_MAX) begin : g_bad_data_w
      $error("uart_tx_frame_gen: DATA_W must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame_gen: STOP_BITS must be 1 or 2");
    end
  endgenerate

  tx_state_e              r_state;
  logic [DATA_W-1:0]      r_data;
  logic                   r_par_bit;
  logic                   r_par_en;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_stop_cnt;

  logic                   w_break;
  logic                   w_idle;
  logic                   w_accept;
  logic                   w_last_bit;
  logic                   w_last_stop;
  logic [DATA_W_MAX-1:0]  w_data_ext;
  tx_sel_e                w_sel;
  logic [CNT_W-1:0]       w_bit_idx;
  logic                   w_data_bit;

`ifdef UART_TX_BREAK_EN
  assign w_break = i_break;
`else
  assign w_break = 1'b0;
`endif

  assign w_idle      = (r_state == IDLE);
  assign o_ready     = w_idle && !w_break;
  assign o_busy      = !w_idle;
  assign w_accept    = i_valid && o_ready;
  assign w_last_bit  = (r_bit_cnt == LAST_BIT);
  assign w_last_stop = (r_stop_cnt == LAST_STOP);

  always_comb begin
    w_data_ext             = '0;
    w_data_ext[DATA_W-1:0] = i_data;
  end

  // The line mux is registered, so it is steered by the level the frame moves to at this edge.
  always_comb begin
    w_sel     = SEL_STOP;
    w_bit_idx = r_bit_cnt;
    case (r_state)
      IDLE:   w_sel = (w_accept || w_break) ? SEL_START : SEL_STOP;
      START: begin
        if (i_baud_tick) begin
          w_sel     = SEL_DATA;
          w_bit_idx = '0;
        end else begin
          w_sel = SEL_START;
        end
      end
      DATA: begin
        w_sel = SEL_DATA;
        if (i_baud_tick) begin
          if (w_last_bit) begin
            w_sel = r_par_en ? SEL_PAR : SEL_STOP;
          end else begin
            w_bit_idx = r_bit_cnt + CNT_W'(1);
          end
        end
      end
      PARITY: w_sel = i_baud_tick ? SEL_STOP : SEL_PAR;
      STOP:   w_sel = (i_baud_tick && w_last_stop && w_break) ? SEL_START : SEL_STOP;
      default: w_sel = SEL_STOP;
    endcase
  end

  assign w_data_bit = r_data[w_bit_idx];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data     <= i_data;
            r_par_bit  <= calc_parity(w_data_ext, i_par_odd);
            r_par_en   <= i_par_en;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_state    <= START;
          end
        end
        START: begin
          if (i_baud_tick) r_state <= DATA;
        end
        DATA: begin
          if (i_baud_tick) begin
            if (w_last_bit) begin
              r_state <= r_par_en ? PARITY : STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (i_baud_tick) r_state <= STOP;
        end
        STOP: begin
          if (i_baud_tick) begin
            if (w_last_stop) begin
              r_state <= IDLE;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_tx_out_mux #(
    .IDLE_LVL (IDLE_LVL)
  ) u_out_mux (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sel      (w_sel),
    .i_data_bit (w_data_bit),
    .i_par_bit  (r_par_bit),
    .o_tx_out   (o_tx_out)
  );

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Bench for uart_tx_frame_gen: two configurations (8N1-style and 5-bit/2-stop) against a frame-level model.
module tb_uart_tx_frame_gen;

  localparam int TICK_DIV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       valid;
  logic       par_en;
  logic       par_odd;
  logic       brk;
  logic [7:0] data;
  logic       tx8, rdy8, busy8;
  logic       tx5, rdy5, busy5;

  int n_chk  = 0;
  int n_fail = 0;
  int tick_cnt = 0;
  int gap;
  logic exp_q[$];

  initial forever #5 clk = ~clk;

  uart_tx_frame_gen #(.DATA_W(8), .STOP_BITS(1), .IDLE_LVL(1'b1)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_data(data), .i_valid(valid),
    .o_ready(rdy8), .i_par_en(par_en), .i_par_odd(par_odd),
`ifdef UART_TX_BREAK_EN
    .i_break(brk),
`endif
    .o_tx_out(tx8), .o_busy(busy8)
  );

  uart_tx_frame_gen #(.DATA_W(5), .STOP_BITS(2), .IDLE_LVL(1'b1)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_data(data[4:0]), .i_valid(valid),
    .o_ready(rdy5), .i_par_en(par_en), .i_par_odd(par_odd),
`ifdef UART_TX_BREAK_EN
    .i_break(brk),
`endif
    .o_tx_out(tx5), .o_busy(busy5)
  );

  // Baud strobe: one clk high every TICK_DIV clks, driven away from the active edge.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (tick_cnt == TICK_DIV - 1);
      tick_cnt = (tick_cnt + 1) % TICK_DIV;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic get_tx(input int w);
    return (w != 0) ? tx5 : tx8;
  endfunction

  function automatic logic get_rdy(input int w);
    return (w != 0) ? rdy5 : rdy8;
  endfunction

  function automatic logic get_busy(input int w);
    return (w != 0) ? busy5 : busy8;
  endfunction

  // Line levels one bit period at a time: start, data LSB first, parity, stops.
  function automatic void build_frame(input logic [7:0] d, input int dw, input logic pe,
                                      input logic po, input int nstop);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < dw; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) exp_q.push_back(((ones % 2) == 1) ^ po);
    for (int i = 0; i < nstop; i++) exp_q.push_back(1'b1);
  endfunction

  task automatic tx_frame(input int w, input logic [7:0] d, input logic pe, input logic po,
                          input logic keep, input int abort_at, input int brk_at,
                          output int gap_o);
    bit got;
    build_frame(d, (w != 0) ? 5 : 8, pe, po, (w != 0) ? 2 : 1);
    gap_o = 0;
    got   = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (get_rdy(w)) begin
        got = 1'b1;
        break;
      end
      gap_o++;
    end
    if (!got) begin
      check_eq("ready_timeout", 0, 1);
      return;
    end
    data = d; par_en = pe; par_odd = po; valid = 1'b1;
    @(posedge clk);
    #1;
    data = 8'($urandom); par_en = 1'($urandom); par_odd = 1'($urandom); valid = keep;
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("w%0d_d%02h_bit%0d", w, d, i), 32'(get_tx(w)), 32'(exp_q[i]));
      check_eq($sformatf("w%0d_busy%0d", w, i), 32'(get_busy(w)), 1);
      if (i == brk_at) brk = 1'b1;
      if (i == abort_at) begin
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_tx", 32'(get_tx(w)), 1);
        check_eq("rst_rdy", 32'(get_rdy(w)), 1);
        check_eq("rst_busy", 32'(get_busy(w)), 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      got = 1'b0;
      for (int k = 0; k < 4 * TICK_DIV; k++) begin
        @(posedge clk);
        if (tick) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        check_eq("tick_timeout", 0, 1);
        return;
      end
      #1;
    end
    check_eq($sformatf("w%0d_end_tx", w), 32'(get_tx(w)), brk ? 0 : 1);
    check_eq($sformatf("w%0d_end_rdy", w), 32'(get_rdy(w)), brk ? 0 : 1);
    check_eq($sformatf("w%0d_end_busy", w), 32'(get_busy(w)), 0);
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; data = '0; par_en = 1'b0; par_odd = 1'b0; brk = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_tx8", 32'(tx8), 1);
    check_eq("reset_rdy8", 32'(rdy8), 1);
    check_eq("reset_busy8", 32'(busy8), 0);
    check_eq("reset_tx5", 32'(tx5), 1);
    check_eq("reset_rdy5", 32'(rdy5), 1);
    check_eq("reset_busy5", 32'(busy5), 0);
    @(negedge clk);
    rst = 1'b0;

    tx_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, -1, -1, gap);
    tx_frame(0, 8'h00, 1'b1, 1'b1, 1'b0, -1, -1, gap);
    tx_frame(0, 8'hFF, 1'b0, 1'b0, 1'b0, -1, -1, gap);
    tx_frame(1, 8'h1F, 1'b0, 1'b0, 1'b0, -1, -1, gap);

    tx_frame(0, 8'h3C, 1'b1, 1'b0, 1'b1, -1, -1, gap);
    tx_frame(0, 8'hC3, 1'b1, 1'b0, 1'b1, -1, -1, gap);
    check_eq("b2b_gap2", gap, 0);
    tx_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, -1, -1, gap);
    check_eq("b2b_gap3", gap, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("b2b_no_extra", 32'(busy8), 0);

    tx_frame(0, 8'($urandom), 1'b1, 1'b0, 1'b0, 4, -1, gap);
    tx_frame(0, 8'h69, 1'b1, 1'b1, 1'b0, -1, -1, gap);

`ifdef UART_TX_BREAK_EN
    tx_frame(0, 8'h96, 1'b1, 1'b0, 1'b0, -1, 5, gap);
    repeat (4) @(posedge clk);
    #1;
    check_eq("break_hold_tx", 32'(tx8), 0);
    check_eq("break_hold_rdy", 32'(rdy8), 0);
    @(negedge clk);
    brk = 1'b0;
    @(posedge clk);
    #1;
    check_eq("break_release_tx", 32'(tx8), 1);
    check_eq("break_release_rdy", 32'(rdy8), 1);
`endif

    for (int n = 0; n < 24; n++) begin
      tx_frame(int'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), -1, -1, gap);
    end
    valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
